// File: rtl/serial_link_fifo_pkg.sv
// Shared constants, FSM state type and helpers for the serial link AXI FIFO writer.
package serial_link_fifo_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ID_WIDTH   = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    RDERR = 2'd3
  } state_e;

  // Beat counter increment that sticks at 255 on runaway bursts
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/serial_link_sat_cnt.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module serial_link_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {Width{1'b1}})) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/serial_link_axi_fifo_writer.sv
// AXI4 subordinate that pushes write beats into a req/gnt FIFO port and
// answers every read burst with SLVERR beats.
module serial_link_axi_fifo_writer
  import serial_link_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DEF_DATA_WIDTH,
  parameter int unsigned IdWidth   = DEF_ID_WIDTH,
  parameter int unsigned AddrWidth = DEF_ADDR_WIDTH,
  parameter int unsigned CntWidth  = DEF_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [7:0]             ar_len_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic                   push_req_o,
  input  logic                   push_gnt_i,
  output logic [DataWidth-1:0]   push_data_o,
  output logic [CntWidth-1:0]    beats_pushed_o,
  output logic [CntWidth-1:0]    err_cnt_o
);

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           beat_q, beat_d;
  logic                 err_q, err_d;
  logic                 push_inc, err_inc;
  logic                 w_hs, strb_zero;

  // Address is accepted but carries no meaning for a FIFO sink
  logic unused_addr;
  assign unused_addr = ^aw_addr_i;

  assign strb_zero   = (w_strb_i == '0);
  assign r_data_o    = '0;
  assign push_data_o = w_data_i;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    push_req_o = 1'b0;
    push_inc   = 1'b0;
    err_inc    = 1'b0;
    w_hs       = 1'b0;
    case (state_q)
      IDLE: begin
        aw_ready_o = 1'b1;
        ar_ready_o = !aw_valid_i;
        if (aw_valid_i) begin
          id_d    = aw_id_i;
          len_d   = aw_len_i;
          beat_d  = 8'd0;
          err_d   = 1'b0;
          state_d = WRITE;
        end else if (ar_valid_i) begin
          id_d    = ar_id_i;
          len_d   = ar_len_i;
          beat_d  = 8'd0;
          state_d = RDERR;
        end
      end
      WRITE: begin
        push_req_o = w_valid_i && !strb_zero;
        w_ready_o  = w_valid_i && (strb_zero || push_gnt_i);
        push_inc   = push_req_o && push_gnt_i;
        w_hs       = w_ready_o;
        if (w_hs) begin
          beat_d = sat_inc8(beat_q);
          // Length mismatch in either direction marks the burst as failed
          if (w_last_i != (beat_q == len_q)) begin
            err_d = 1'b1;
          end
          if (w_last_i) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (b_ready_i) begin
          err_inc = err_q;
          state_d = IDLE;
        end
      end
      RDERR: begin
        if (r_ready_i) begin
          beat_d = sat_inc8(beat_q);
          if (beat_q == len_q) begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response channels are registered from the next-state view so they
  // appear no earlier than one cycle after the triggering handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      b_valid_o <= 1'b0;
      b_id_o    <= '0;
      b_resp_o  <= RESP_OKAY;
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_resp_o  <= RESP_OKAY;
      r_last_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      b_valid_o <= (state_d == WRESP);
      b_id_o    <= (state_d == WRESP) ? id_d : '0;
      b_resp_o  <= ((state_d == WRESP) && err_d) ? RESP_SLVERR : RESP_OKAY;
      r_valid_o <= (state_d == RDERR);
      r_id_o    <= (state_d == RDERR) ? id_d : '0;
      r_resp_o  <= (state_d == RDERR) ? RESP_SLVERR : RESP_OKAY;
      r_last_o  <= (state_d == RDERR) && (beat_d == len_d);
    end
  end

  serial_link_sat_cnt #(.Width(CntWidth)) u_pushed_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(1'b0),
    .inc_i  (push_inc),
    .cnt_o  (beats_pushed_o)
  );

  serial_link_sat_cnt #(.Width(CntWidth)) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(1'b0),
    .inc_i  (err_inc),
    .cnt_o  (err_cnt_o)
  );

endmodule

// File: tb/tb_serial_link_axi_fifo_writer.sv
// Scoreboard bench: stimulus queues expected pushes/B/R beats, a negedge
// monitor pops and compares them on each DUT handshake.
module tb_serial_link_axi_fifo_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic          last;
  } r_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aw_valid = 1'b0, aw_ready;
  logic [IW-1:0] aw_id = '0;
  logic [AW-1:0] aw_addr = '0;
  logic [7:0]    aw_len = '0;
  logic          w_valid = 1'b0, w_ready;
  logic [DW-1:0] w_data = '0;
  logic [DW/8-1:0] w_strb = '0;
  logic          w_last = 1'b0;
  logic          b_valid, b_ready = 1'b1;
  logic [IW-1:0] b_id;
  logic [1:0]    b_resp;
  logic          ar_valid = 1'b0, ar_ready;
  logic [IW-1:0] ar_id = '0;
  logic [7:0]    ar_len = '0;
  logic          r_valid, r_ready = 1'b1;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_last;
  logic          push_req, push_gnt = 1'b1;
  logic [DW-1:0] push_data;
  logic [CW-1:0] beats_pushed, err_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] push_q[$];
  b_exp_t        b_q[$];
  r_exp_t        r_q[$];

  always #5 clk = ~clk;

  serial_link_axi_fifo_writer #(
    .DataWidth(DW), .IdWidth(IW), .AddrWidth(AW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
    .aw_addr_i(aw_addr), .aw_len_i(aw_len),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
    .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .push_req_o(push_req), .push_gnt_i(push_gnt), .push_data_o(push_data),
    .beats_pushed_o(beats_pushed), .err_cnt_o(err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handshake against the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (push_req && push_gnt) begin
        checks++;
        if (push_q.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: got 0x%0h expected none", push_data);
        end else begin
          logic [DW-1:0] e;
          e = push_q.pop_front();
          if (push_data !== e) begin
            errors++;
            $display("FAIL push_data: got 0x%0h expected 0x%0h", push_data, e);
          end
        end
      end
      if (b_valid && b_ready) begin
        checks++;
        if (b_q.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got id %0d resp %0d expected none", b_id, b_resp);
        end else begin
          b_exp_t e;
          e = b_q.pop_front();
          if (b_id !== e.id || b_resp !== e.resp) begin
            errors++;
            $display("FAIL b_beat: got id %0d resp %0d expected id %0d resp %0d",
                     b_id, b_resp, e.id, e.resp);
          end
        end
      end
      if (r_valid && r_ready) begin
        checks++;
        if (r_q.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got id %0d expected none", r_id);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          if (r_id !== e.id || r_resp !== e.resp || r_data !== e.data || r_last !== e.last) begin
            errors++;
            $display("FAIL r_beat: got id %0d resp %0d data 0x%0h last %0d expected id %0d resp %0d data 0x%0h last %0d",
                     r_id, r_resp, r_data, r_last, e.id, e.resp, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name, ref logic rdy);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no ready expected ready within 200 cycles", name);
    end
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [7:0] len);
    aw_valid = 1'b1; aw_id = id; aw_len = len; aw_addr = 32'h1000_0000;
    wait_ready("aw", aw_ready);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [7:0] len);
    ar_valid = 1'b1; ar_id = id; ar_len = len;
    wait_ready("ar", ar_ready);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s, input logic l, input int stall);
    w_valid = 1'b1; w_data = d; w_strb = s; w_last = l;
    if (stall > 0) begin
      push_gnt = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        chk("stall_w_ready", 64'(w_ready), 64'd0);
        chk("stall_push_req", 64'(push_req), 64'd1);
      end
      @(posedge clk); #1;
      push_gnt = 1'b1;
    end
    wait_ready("w", w_ready);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  // Wait for all queued expectations, optionally toggling r_ready each cycle
  task automatic drain(input bit toggle_r);
    int n;
    n = 0;
    while ((push_q.size() + b_q.size() + r_q.size()) != 0 && n < 300) begin
      @(posedge clk); #1;
      if (toggle_r) r_ready = ~r_ready;
      n++;
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_outstanding", 64'(push_q.size() + b_q.size() + r_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_push_req", 64'(push_req), 64'd0);
    chk("rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("rst_counters", {32'(beats_pushed), 32'(err_cnt)}, 64'd0);
    @(posedge clk); #1;

    // Clean burst
    push_q.push_back(32'h11); push_q.push_back(32'h22);
    push_q.push_back(32'h33); push_q.push_back(32'h44);
    b_q.push_back('{id: 4'd3, resp: 2'b00});
    send_aw(4'd3, 8'd3);
    send_w(32'h11, 4'hF, 1'b0, 0);
    send_w(32'h22, 4'hF, 1'b0, 0);
    send_w(32'h33, 4'hF, 1'b0, 0);
    send_w(32'h44, 4'hF, 1'b1, 0);
    drain(1'b0);
    chk("clean_beats_pushed", 64'(beats_pushed), 64'd4);
    chk("clean_err_cnt", 64'(err_cnt), 64'd0);

    // Backpressure on beat 2
    push_q.push_back(32'h11); push_q.push_back(32'h22);
    push_q.push_back(32'h33); push_q.push_back(32'h44);
    b_q.push_back('{id: 4'd3, resp: 2'b00});
    send_aw(4'd3, 8'd3);
    send_w(32'h11, 4'hF, 1'b0, 0);
    send_w(32'h22, 4'hF, 1'b0, 5);
    send_w(32'h33, 4'hF, 1'b0, 0);
    send_w(32'h44, 4'hF, 1'b1, 0);
    drain(1'b0);
    chk("bp_beats_pushed", 64'(beats_pushed), 64'd8);

    // Short burst
    push_q.push_back(32'h55); push_q.push_back(32'h66);
    b_q.push_back('{id: 4'd1, resp: 2'b10});
    send_aw(4'd1, 8'd3);
    send_w(32'h55, 4'hF, 1'b0, 0);
    send_w(32'h66, 4'hF, 1'b1, 0);
    drain(1'b0);
    chk("short_err_cnt", 64'(err_cnt), 64'd1);
    chk("short_beats_pushed", 64'(beats_pushed), 64'd10);

    // Zero strobe beat is consumed without a push
    push_q.push_back(32'hAB);
    b_q.push_back('{id: 4'd2, resp: 2'b00});
    send_aw(4'd2, 8'd1);
    send_w(32'hDEAD, 4'h0, 1'b0, 0);
    send_w(32'hAB, 4'hF, 1'b1, 0);
    drain(1'b0);
    chk("zstrb_beats_pushed", 64'(beats_pushed), 64'd11);
    chk("zstrb_err_cnt", 64'(err_cnt), 64'd1);

    // Read rejection with toggling r_ready
    r_q.push_back('{id: 4'd5, resp: 2'b10, data: 32'h0, last: 1'b0});
    r_q.push_back('{id: 4'd5, resp: 2'b10, data: 32'h0, last: 1'b0});
    r_q.push_back('{id: 4'd5, resp: 2'b10, data: 32'h0, last: 1'b1});
    send_ar(4'd5, 8'd2);
    drain(1'b1);
    chk("read_err_cnt", 64'(err_cnt), 64'd2);
    chk("read_r_valid_idle", 64'(r_valid), 64'd0);

    // Simultaneous AW and AR: write wins, read waits for B
    push_q.push_back(32'h77);
    b_q.push_back('{id: 4'd6, resp: 2'b00});
    r_q.push_back('{id: 4'd7, resp: 2'b10, data: 32'h0, last: 1'b1});
    b_ready = 1'b0;
    aw_valid = 1'b1; aw_id = 4'd6; aw_len = 8'd0;
    ar_valid = 1'b1; ar_id = 4'd7; ar_len = 8'd0;
    @(negedge clk);
    chk("arb_aw_ready", 64'(aw_ready), 64'd1);
    chk("arb_ar_ready", 64'(ar_ready), 64'd0);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    send_w(32'h77, 4'hF, 1'b1, 0);
    @(negedge clk);
    chk("arb_b_valid", 64'(b_valid), 64'd1);
    chk("arb_ar_blocked", 64'(ar_ready), 64'd0);
    @(posedge clk); #1;
    b_ready = 1'b1;
    wait_ready("arb_ar", ar_ready);
    chk("arb_b_before_ar", 64'(b_q.size()), 64'd0);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    drain(1'b0);
    chk("arb_err_cnt", 64'(err_cnt), 64'd3);
    chk("arb_beats_pushed", 64'(beats_pushed), 64'd12);

    // Mid-burst reset drops the burst without a B
    push_q.push_back(32'h88); push_q.push_back(32'h99);
    send_aw(4'd4, 8'd3);
    send_w(32'h88, 4'hF, 1'b0, 0);
    send_w(32'h99, 4'hF, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_b_valid", 64'(b_valid), 64'd0);
    chk("mrst_r_valid", 64'(r_valid), 64'd0);
    chk("mrst_push_req", 64'(push_req), 64'd0);
    chk("mrst_counters", {32'(beats_pushed), 32'(err_cnt)}, 64'd0);
    chk("mrst_aw_ready", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    push_q.push_back(32'hC3);
    b_q.push_back('{id: 4'd8, resp: 2'b00});
    send_aw(4'd8, 8'd0);
    send_w(32'hC3, 4'hF, 1'b1, 0);
    drain(1'b0);
    chk("mrst_beats_pushed", 64'(beats_pushed), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
